add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arb_pkg.sv | 13 +
 rtl/add32.sv | 18 +
 rtl/add_arbiter.sv | 101 ++++++++++
 tb/tb_add_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// Shared definitions for the two-requester add arbiter: the default
// operand width and the three-state controller encoding.
package add_arb_pkg;

   localparam int ADD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } arbState_t;

endpackage

// File: rtl/add32.sv
// Purely combinational adder. The result is one bit wider than the operands
// so the top bit carries the carry-out of the addition.
module add32
   import add_arb_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum
);

   // Zero-extend both operands so the carry lands in the extra bit
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
   end

endmodule

// File: rtl/add_arbiter.sv
// Two-requester round-robin front end for a shared adder. A requester is
// granted in IDLE, its operands are summed in CALC, and the result is held in
// DONE until the consumer takes it.
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_carry,
   output logic             res_id,
   output logic             busy
);

   arbState_t        state_q;
   logic             ptr_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [WIDTH-1:0] resSum_q;
   logic             resCarry_q;
   logic             resId_q;
   logic [WIDTH:0]   sum_d;
   logic             grant1;
   logic             anyValid;
   logic             isIdle;

   add32 #(.WIDTH(WIDTH)) u_add32 (
      .a   (opA_q),
      .b   (opB_q),
      .sum (sum_d)
   );

   // Pick requester 1 when it is alone, or when both ask and the pointer
   // prefers it; otherwise requester 0 wins whenever it is valid
   always_comb begin
      anyValid = req0_valid | req1_valid;
      grant1   = req1_valid & (~req0_valid | ptr_q);
      isIdle   = (state_q == IDLE);
   end

   // Ready is only offered in IDLE to the winner; rst masks it so nothing
   // looks accepted while the block is being cleared
   assign req0_ready = ~rst & isIdle & req0_valid & ~grant1;
   assign req1_ready = ~rst & isIdle & grant1;
   assign res_valid  = (state_q == DONE);
   assign busy       = ~isIdle;
   assign res_sum    = resSum_q;
   assign res_carry  = resCarry_q;
   assign res_id     = resId_q;

   // Controller: latch the winner's operands, register the sum one cycle
   // later, then hold the result until the consumer accepts it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         opA_q      <= '0;
         opB_q      <= '0;
         resSum_q   <= '0;
         resCarry_q <= 1'b0;
         resId_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (anyValid) begin
                  opA_q   <= grant1 ? req1_a : req0_a;
                  opB_q   <= grant1 ? req1_b : req0_b;
                  resId_q <= grant1;
                  ptr_q   <= ~grant1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               {resCarry_q, resSum_q} <= sum_d;
               state_q                <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed testbench for add_arbiter. Inputs are driven and outputs sampled on
// the falling edge so nothing races the rising edge the design uses.
module tb_add_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        req1_ready;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_sum;
   logic        res_carry;
   logic        res_id;
   logic        busy;

   int testsRun    = 0;
   int testsFailed = 0;

   add_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_carry  (res_carry),
      .res_id     (res_id),
      .busy       (busy)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Drive both requester ports in one go
   task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [31:0] a1, input logic [31:0] b1);
      req0_valid = v0;
      req0_a     = a0;
      req0_b     = b0;
      req1_valid = v1;
      req1_a     = a1;
      req1_b     = b1;
   endtask

   // Clean reset with idle inputs, released on a falling edge
   task automatic doReset();
      rst       = 1'b1;
      res_ready = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Step falling edges until res_valid shows up or the budget runs out
   task automatic waitForResult(input int maxCycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Everything reads zero while rst is high, even with requests pending,
   // and a rising edge under reset does not start a transaction
   task automatic test_reset();
      rst       = 1'b1;
      res_ready = 1'b1;
      applyStimulus(1'b1, 32'd3, 32'd4, 1'b1, 32'd5, 32'd6);
      @(negedge clk);
      @(negedge clk);
      testsRun++;
      if ({res_valid, busy, req0_ready, req1_ready, res_carry, res_id} !== 6'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got {valid,busy,rdy0,rdy1,carry,id}=%b expected 000000",
                  {res_valid, busy, req0_ready, req1_ready, res_carry, res_id});
      end
      testsRun++;
      if (res_sum !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_sum: got %h expected 00000000", res_sum);
      end
   endtask

   // Lone request: ready for one cycle, result two edges on, sum 0+1
   task automatic test_single();
      bit ok;
      doReset();
      applyStimulus(1'b1, 32'd0, 32'd1, 1'b0, 32'd0, 32'd0);
      #1;
      testsRun++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL single_ready: got rdy0,rdy1=%b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      testsRun++;
      if ({busy, res_valid, req0_ready} !== 3'b100) begin
         testsFailed++;
         $display("[TB] FAIL single_calc: got busy,valid,rdy0=%b expected 100", {busy, res_valid, req0_ready});
      end
      @(negedge clk);
      testsRun++;
      if ({res_valid, res_sum, res_carry, res_id} !== {1'b1, 32'd1, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL single_result: got valid=%b sum=%h carry=%b id=%b expected 1 00000001 0 0",
                  res_valid, res_sum, res_carry, res_id);
      end
      @(negedge clk);
      testsRun++;
      if ({res_valid, busy} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL single_return: got valid,busy=%b expected 00", {res_valid, busy});
      end
      ok = 1'b1;
   endtask

   // Both valid straight out of reset: requester 0 first, then requester 1
   task automatic test_contention();
      bit ok;
      rst       = 1'b1;
      res_ready = 1'b1;
      applyStimulus(1'b1, 32'h0000FFFF, 32'd1, 1'b1, 32'h0002CCC1, 32'h0000FFFF);
      @(negedge clk);
      testsRun++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL contention_ready_in_reset: got %b expected 00", {req0_ready, req1_ready});
      end
      rst = 1'b0;
      #1;
      testsRun++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL contention_first_grant: got rdy0,rdy1=%b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      waitForResult(20, ok);
      testsRun++;
      if (!ok || res_id !== 1'b0 || res_sum !== 32'h00010000 || res_carry !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL contention_result0: got seen=%0d id=%b sum=%h carry=%b expected 1 0 00010000 0",
                  ok, res_id, res_sum, res_carry);
      end
      @(negedge clk);
      testsRun++;
      if (req1_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL contention_second_grant: got rdy1=%b expected 1", req1_ready);
      end
      @(negedge clk);
      req1_valid = 1'b0;
      waitForResult(20, ok);
      testsRun++;
      if (!ok || res_id !== 1'b1 || res_sum !== 32'h0003CCC0 || res_carry !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL contention_result1: got seen=%0d id=%b sum=%h carry=%b expected 1 1 0003ccc0 0",
                  ok, res_id, res_sum, res_carry);
      end
      @(negedge clk);
   endtask

   // Both requesters held valid: six results must alternate 0,1,0,1,0,1
   task automatic test_round_robin();
      int seen;
      logic [31:0] expSum;
      doReset();
      applyStimulus(1'b1, 32'd1, 32'd2, 1'b1, 32'd10, 32'd20);
      seen = 0;
      for (int cyc = 0; cyc < 60 && seen < 6; cyc++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            expSum = (seen % 2 == 0) ? 32'd3 : 32'd30;
            testsRun++;
            if (res_id !== seen[0] || res_sum !== expSum) begin
               testsFailed++;
               $display("[TB] FAIL round_robin_%0d: got id=%b sum=%h expected id=%b sum=%h",
                        seen, res_id, res_sum, seen[0], expSum);
            end
            seen++;
         end
      end
      testsRun++;
      if (seen != 6) begin
         testsFailed++;
         $display("[TB] FAIL round_robin_count: got %0d results expected 6", seen);
      end
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Result held for five stalled cycles; operand changes after accept and a
   // waiting requester must not disturb it
   task automatic test_backpressure();
      bit ok;
      doReset();
      res_ready = 1'b0;
      applyStimulus(1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      applyStimulus(1'b0, 32'hDEAD0000, 32'h0000BEEF, 1'b1, 32'd100, 32'd200);
      waitForResult(20, ok);
      testsRun++;
      if (!ok) begin
         testsFailed++;
         $display("[TB] FAIL backpressure_arrive: got no result expected res_valid within 20 cycles");
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         testsRun++;
         if ({res_valid, req0_ready, req1_ready, res_id} !== 4'b1000 || res_sum !== 32'd12) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_hold_%0d: got valid,rdy0,rdy1,id=%b sum=%h expected 1000 0000000c",
                     i, {res_valid, req0_ready, req1_ready, res_id}, res_sum);
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      testsRun++;
      if ({res_valid, busy, req1_ready} !== 3'b001) begin
         testsFailed++;
         $display("[TB] FAIL backpressure_release: got valid,busy,rdy1=%b expected 001",
                  {res_valid, busy, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      waitForResult(20, ok);
      testsRun++;
      if (!ok || res_id !== 1'b1 || res_sum !== 32'd300) begin
         testsFailed++;
         $display("[TB] FAIL backpressure_next: got seen=%0d id=%b sum=%h expected 1 1 0000012c", ok, res_id, res_sum);
      end
      @(negedge clk);
   endtask

   // All-ones plus one from a lone requester 1: sum wraps, carry set
   task automatic test_wrap();
      bit ok;
      doReset();
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1);
      @(negedge clk);
      req1_valid = 1'b0;
      waitForResult(20, ok);
      testsRun++;
      if (!ok || res_sum !== 32'd0 || res_carry !== 1'b1 || res_id !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL wrap: got seen=%0d sum=%h carry=%b id=%b expected 1 00000000 1 1",
                  ok, res_sum, res_carry, res_id);
      end
      @(negedge clk);
   endtask

   // Reset mid-CALC drops the job at once; afterwards the pointer is back to 0
   task automatic test_reset_in_calc();
      bit ok;
      bit leaked;
      doReset();
      applyStimulus(1'b1, 32'd10, 32'd20, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      testsRun++;
      if (busy !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_calc_entered: got busy=%b expected 1", busy);
      end
      #1;
      rst = 1'b1;
      #1;
      testsRun++;
      if ({busy, res_valid} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL reset_calc_async: got busy,valid=%b expected 00", {busy, res_valid});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      leaked = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
      end
      testsRun++;
      if (leaked) begin
         testsFailed++;
         $display("[TB] FAIL reset_calc_discard: got a result or busy after reset expected none");
      end
      applyStimulus(1'b1, 32'd100, 32'd23, 1'b1, 32'd7, 32'd8);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      waitForResult(20, ok);
      testsRun++;
      if (!ok || res_id !== 1'b0 || res_sum !== 32'd123 || res_carry !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_calc_after: got seen=%0d id=%b sum=%h carry=%b expected 1 0 0000007b 0",
                  ok, res_id, res_sum, res_carry);
      end
      @(negedge clk);
   endtask

   // Run every scenario in order, then report
   initial begin
      rst       = 1'b1;
      res_ready = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      test_reset();
      test_single();
      test_contention();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_in_calc();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
